div_share_seq: RTL and testbench

//  Iterative non-restoring divider shared by two requesters; one quotient bit per cycle.

---
 rtl/div_share_seq.sv | 155 +++++++++++++++
 tb/tb_div_share_seq.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_seq.sv
// div_share_seq: iterative non-restoring divider shared by two requesters.
//
// One quotient bit is produced per cycle. A round-robin arbiter picks one requester while
// idle; the FSM then runs DW iterations, corrects a negative remainder once and presents
// the result, tagged with the requester id, until the consumer takes it.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   req0_valid/ready/a/b     requester 0 operation handshake and operands
//   req1_valid/ready/a/b     requester 1 operation handshake and operands
//   rsp_valid/ready          result handshake
//   rsp_id                   requester that issued the result
//   rsp_quot, rsp_rem        quotient and remainder (zero while rsp_valid is low)
//   rsp_dbz                  divide-by-zero flag
module div_share_seq #(
  parameter int unsigned DW = 4,
  parameter int unsigned BW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [BW-1:0] req0_b,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [BW-1:0] req1_b,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_quot,
  output logic [BW-1:0] rsp_rem,
  output logic          rsp_dbz
);

  // Partial remainder needs two guard bits: one for the shift, one for the sign.
  localparam int unsigned PW = BW + 2;
  localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {StIdle, StIter, StFix, StResp} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] p_q, p_d;
  logic [DW-1:0] q_q, q_d;
  logic [PW-1:0] d_q, d_d;
  logic          id_q, id_d;
  logic          dbz_q, dbz_d;
  // Requester that wins a tie: the one not served last.
  logic          prio_q, prio_d;

  logic          grant0, grant1, accept;
  logic [DW-1:0] a_sel;
  logic [BW-1:0] b_sel;
  logic [PW-1:0] p_sh, p_step;

  assign grant0 = req0_valid & (~req1_valid | ~prio_q);
  assign grant1 = req1_valid & (~req0_valid | prio_q);
  assign accept = (state_q == StIdle) & (grant0 | grant1);

  assign req0_ready = (state_q == StIdle) & grant0;
  assign req1_ready = (state_q == StIdle) & grant1;

  assign a_sel = grant1 ? req1_a : req0_a;
  assign b_sel = grant1 ? req1_b : req0_b;

  // {P,Q} shifted left by one, then add or subtract D depending on the pre-shift sign.
  assign p_sh   = {p_q[PW-2:0], q_q[DW-1]};
  assign p_step = p_q[PW-1] ? (p_sh + d_q) : (p_sh - d_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    q_d     = q_q;
    d_d     = d_q;
    id_d    = id_q;
    dbz_d   = dbz_q;
    prio_d  = prio_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          id_d   = grant1;
          prio_d = ~grant1;
          if (b_sel == '0) begin
            p_d     = {{2{1'b0}}, a_sel[BW-1:0]};
            q_d     = '1;
            d_d     = '0;
            dbz_d   = 1'b1;
            state_d = StResp;
          end else begin
            p_d     = '0;
            q_d     = a_sel;
            d_d     = {{2{1'b0}}, b_sel};
            cnt_d   = CW'(DW - 1);
            dbz_d   = 1'b0;
            state_d = StIter;
          end
        end
      end
      StIter: begin
        p_d = p_step;
        q_d = {q_q[DW-2:0], ~p_step[PW-1]};
        if (cnt_q == '0) begin
          state_d = StFix;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StFix: begin
        if (p_q[PW-1]) begin
          p_d = p_q + d_q;
        end
        state_d = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      p_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      id_q    <= 1'b0;
      dbz_q   <= 1'b0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      q_q     <= q_d;
      d_q     <= d_d;
      id_q    <= id_d;
      dbz_q   <= dbz_d;
      prio_q  <= prio_d;
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_id    = rsp_valid & id_q;
  assign rsp_dbz   = rsp_valid & dbz_q;
  assign rsp_quot  = rsp_valid ? q_q : '0;
  assign rsp_rem   = rsp_valid ? p_q[BW-1:0] : '0;

endmodule

// File: tb/tb_div_share_seq.sv
// Bench for div_share_seq (DW=4, BW=2): vector table, hand-written corner sequences,
// exhaustive operand sweep and random operations against an arithmetic model.
module tb_div_share_seq;

  localparam int DW = 4;
  localparam int BW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [DW-1:0] req0_a, req1_a;
  logic [BW-1:0] req0_b, req1_b;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_dbz;
  logic [DW-1:0] rsp_quot;
  logic [BW-1:0] rsp_rem;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_share_seq #(.DW(DW), .BW(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_quot   (rsp_quot),
    .rsp_rem    (rsp_rem),
    .rsp_dbz    (rsp_dbz)
  );

  typedef struct {
    int id;
    int a;
    int b;
    int eq;
    int er;
    int edbz;
    int elat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: plain integer division; divide by zero gives all-ones and the low dividend bits.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int dbz);
    if (b == 0) begin
      q   = (1 << DW) - 1;
      r   = a % (1 << BW);
      dbz = 1;
    end else begin
      q   = a / b;
      r   = a % b;
      dbz = 0;
    end
  endfunction

  task automatic check_idle_zero(input string tag);
    check({tag, " rsp_valid"}, rsp_valid, 0);
    check({tag, " rsp_id"}, rsp_id, 0);
    check({tag, " rsp_quot"}, rsp_quot, 0);
    check({tag, " rsp_rem"}, rsp_rem, 0);
    check({tag, " rsp_dbz"}, rsp_dbz, 0);
    check({tag, " req0_ready"}, req0_ready, 0);
    check({tag, " req1_ready"}, req1_ready, 0);
  endtask

  // One operation from one requester with rsp_ready held high; checks result and latency.
  task automatic run_op(input int id, input int a, input int b, input int elat,
                        input string tag);
    int eq, er, edbz, lat, waitc;
    model(a, b, eq, er, edbz);
    @(negedge clk);
    rsp_ready = 1'b1;
    if (id == 1) begin
      req1_valid = 1'b1; req1_a = DW'(a); req1_b = BW'(b);
    end else begin
      req0_valid = 1'b1; req0_a = DW'(a); req0_b = BW'(b);
    end
    #1;
    waitc = 0;
    while (!((id == 1) ? req1_ready : req0_ready) && waitc < 20) begin
      @(negedge clk);
      #1;
      waitc++;
    end
    if (waitc >= 20) begin
      check({tag, " accept timeout"}, 0, 1);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, lat, elat);
    check({tag, " id"}, rsp_id, id);
    check({tag, " quot"}, rsp_quot, eq);
    check({tag, " rem"}, rsp_rem, er);
    check({tag, " dbz"}, rsp_dbz, edbz);
    @(negedge clk);
    check({tag, " consumed"}, rsp_valid, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   gq[$];
    int   gcyc[$];
    int   nresp, cyc, eq, er, edbz, waitc, seen, ra, rb;
    logic [DW-1:0] hq;
    logic [BW-1:0] hr;

    vecs[0] = '{0, 13, 3, 4, 1, 0, DW + 2};
    vecs[1] = '{1, 15, 1, 15, 0, 0, DW + 2};
    vecs[2] = '{0, 2, 3, 0, 2, 0, DW + 2};
    vecs[3] = '{0, 9, 0, 15, 1, 1, 1};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;

    // Both requesters continuously valid: grants alternate starting with req0.
    req0_a = 4'd13; req0_b = 2'd3;
    req1_a = 4'd15; req1_b = 2'd1;
    nresp = 0;
    cyc = 0;
    while (nresp < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      req0_valid = (gq.size() < 4);
      req1_valid = (gq.size() < 4);
      #1;
      if (req0_ready && req1_ready) check("alt both ready", 1, 0);
      if (req0_ready) begin
        gq.push_back(0); gcyc.push_back(cyc);
      end else if (req1_ready) begin
        gq.push_back(1); gcyc.push_back(cyc);
      end
      if (rsp_valid && nresp < gq.size()) begin
        if (gq[nresp] == 1) model(15, 1, eq, er, edbz);
        else model(13, 3, eq, er, edbz);
        check("alt rsp id", rsp_id, gq[nresp]);
        check("alt rsp quot", rsp_quot, eq);
        check("alt rsp rem", rsp_rem, er);
        nresp++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("alt responses", nresp, 4);
    check("alt grants", gq.size(), 4);
    for (int i = 0; i < gq.size(); i++) begin
      check($sformatf("alt grant %0d", i), gq[i], i % 2);
      if (i > 0) check($sformatf("alt spacing %0d", i), gcyc[i] - gcyc[i-1], DW + 3);
    end

    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].elat, $sformatf("vec%0d", i));
    end

    // Backpressure: result held stable while rsp_ready is low, requesters ignored.
    @(negedge clk);
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 4'd11; req1_b = 2'd2;
    #1;
    check("bp accept", req1_ready, 1);
    @(negedge clk);
    req1_valid = 1'b0;
    waitc = 0;
    while (!rsp_valid && waitc < 40) begin
      @(negedge clk);
      waitc++;
    end
    check("bp rsp_valid", rsp_valid, 1);
    hq = rsp_quot;
    hr = rsp_rem;
    check("bp quot", hq, 5);
    check("bp rem", hr, 1);
    req0_valid = 1'b1; req0_a = 4'd5; req0_b = 2'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      check("bp hold valid", rsp_valid, 1);
      check("bp hold quot", rsp_quot, 5);
      check("bp hold rem", rsp_rem, 1);
      check("bp hold id", rsp_id, 1);
      check("bp hold dbz", rsp_dbz, 0);
      check("bp req0_ready", req0_ready, 0);
      check("bp req1_ready", req1_ready, 0);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    check_idle_zero("bp after");

    // Reset during iteration aborts the operation with no response.
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd13; req0_b = 2'd3;
    #1;
    check("abort accept", req0_ready, 1);
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_idle_zero("abort reset");
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
    end
    check("abort no response", seen, 0);
    // Last served was req0, but reset restores the pointer to favour req0.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("abort prio req0", req0_ready, 1);
    check("abort prio req1", req1_ready, 0);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;

    for (int a = 0; a < (1 << DW); a++) begin
      for (int b = 0; b < (1 << BW); b++) begin
        run_op(int'($urandom_range(0, 1)), a, b, (b == 0) ? 1 : DW + 2,
               $sformatf("sweep a=%0d b=%0d", a, b));
      end
    end

    for (int i = 0; i < 20; i++) begin
      ra = int'($urandom % (1 << DW));
      rb = int'($urandom % (1 << BW));
      run_op(int'($urandom_range(0, 1)), ra, rb, (rb == 0) ? 1 : DW + 2,
             $sformatf("rand a=%0d b=%0d", ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
